// File: rtl/if_stage_pkg.sv
// Shared constants, selector encoding and offset helper for the MIPS
// instruction-fetch stage.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam int unsigned IMEM_WORDS_DEFAULT = 4096;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    function automatic logic [31:0] br_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's pipeline-control, imem and IF/ID signals.
interface if_stage_if;

    logic        stall;
    logic        br;
    logic        is_j;
    logic        is_jr;
    logic [15:0] imm16_d;
    logic [25:0] index26_d;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;
    logic        fetch_fault;

    modport slave (
        input  stall, br, is_j, is_jr, imm16_d, index26_d, jr_target, imem_rdata,
        output imem_addr, instr_d, pc_d, pc8_d, valid_d, fetch_fault
    );

    modport master (
        output stall, br, is_j, is_jr, imm16_d, index26_d, jr_target, imem_rdata,
        input  imem_addr, instr_d, pc_d, pc8_d, valid_d, fetch_fault
    );

endinterface

// File: rtl/if_stage_npc.sv
// Combinational next-PC selection: jr > j > branch > sequential.
module npc
    import if_stage_pkg::*;
(
    input  logic [31:0] i_pc_f,
    input  logic [31:0] i_pc_d,
    input  logic [15:0] i_imm16_d,
    input  logic [25:0] i_index26_d,
    input  logic [31:0] i_jr_target,
    input  logic        i_br,
    input  logic        i_is_j,
    input  logic        i_is_jr,
    output logic [31:0] o_npc
);

    logic [31:0] w_pc_d4;
    npc_sel_e    w_sel;

    assign w_pc_d4 = i_pc_d + 32'd4;

    // Resolve the redirect source in fixed priority order
    always_comb begin
        w_sel = NPC_SEQ;
        if (i_is_jr) begin
            w_sel = NPC_JR;
        end else if (i_is_j) begin
            w_sel = NPC_J;
        end else if (i_br) begin
            w_sel = NPC_BR;
        end else begin
            w_sel = NPC_SEQ;
        end
    end

    // Target computation; branch and jump are relative to the delay slot
    always_comb begin
        o_npc = i_pc_f + 32'd4;
        case (w_sel)
            NPC_JR:  o_npc = i_jr_target;
            NPC_J:   o_npc = {w_pc_d4[31:28], i_index26_d, 2'b00};
            NPC_BR:  o_npc = w_pc_d4 + br_offset(i_imm16_d);
            NPC_SEQ: o_npc = i_pc_f + 32'd4;
            default: o_npc = i_pc_f + 32'd4;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem range check, IF/ID register
// and sticky fetch-fault flag around the npc selector.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    if_stage_if.slave  bus
);

    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

    logic [31:0] r_pc_f;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic        r_valid_d;
    logic        r_fetch_fault;

    logic [31:0] w_npc;
    logic [31:0] w_offset;
    logic        w_in_range;

    npc u_npc (
        .i_pc_f      (r_pc_f),
        .i_pc_d      (r_pc_d),
        .i_imm16_d   (bus.imm16_d),
        .i_index26_d (bus.index26_d),
        .i_jr_target (bus.jr_target),
        .i_br        (bus.br),
        .i_is_j      (bus.is_j),
        .i_is_jr     (bus.is_jr),
        .o_npc       (w_npc)
    );

    // Unsigned subtraction folds both below-base and above-top into one compare
    assign w_offset   = r_pc_f - RESET_PC;
    assign w_in_range = (r_pc_f[1:0] == 2'b00) && (w_offset < IMEM_BYTES);

    // PC and IF/ID register; stall freezes everything, including redirects
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc_f    <= RESET_PC;
            r_instr_d <= NOP_INSTR;
            r_pc_d    <= 32'h0000_0000;
            r_valid_d <= 1'b0;
        end else if (!bus.stall) begin
            r_pc_f    <= w_npc;
            r_instr_d <= w_in_range ? bus.imem_rdata : NOP_INSTR;
            r_pc_d    <= r_pc_f;
            r_valid_d <= w_in_range;
        end
    end

    // Sticky fault, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_fault <= 1'b0;
        end else if (!bus.stall && !w_in_range) begin
            r_fetch_fault <= 1'b1;
        end
    end

    assign bus.imem_addr   = r_pc_f;
    assign bus.instr_d     = r_instr_d;
    assign bus.pc_d        = r_pc_d;
    assign bus.pc8_d       = r_pc_d + 32'd8;
    assign bus.valid_d     = r_valid_d;
    assign bus.fetch_fault = r_fetch_fault;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized
// control traffic against a behavioural fetch-stage model.
module tb_if_stage;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] IMEM_BYTES = 32'd16384;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    logic [31:0] m_pc_f;
    logic [31:0] m_instr_d;
    logic [31:0] m_pc_d;
    logic        m_valid_d;
    logic        m_fault;

    if_stage_if bus ();

    if_stage #(.RESET_PC(RESET_PC), .IMEM_WORDS(4096)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0] ^ 16'hA5A5, ~addr[15:0]};
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc_f    = RESET_PC;
        m_instr_d = 32'h0;
        m_pc_d    = 32'h0;
        m_valid_d = 1'b0;
        m_fault   = 1'b0;
    endtask

    task automatic compare_all();
        check_eq("imem_addr", bus.imem_addr, m_pc_f);
        check_eq("instr_d", bus.instr_d, m_instr_d);
        check_eq("pc_d", bus.pc_d, m_pc_d);
        check_eq("pc8_d", bus.pc8_d, m_pc_d + 32'd8);
        check_eq("valid_d", {31'b0, bus.valid_d}, {31'b0, m_valid_d});
        check_eq("fetch_fault", {31'b0, bus.fetch_fault}, {31'b0, m_fault});
    endtask

    task automatic check_reset_values();
        check_eq("rst_imem_addr", bus.imem_addr, RESET_PC);
        check_eq("rst_instr_d", bus.instr_d, 32'h0);
        check_eq("rst_pc_d", bus.pc_d, 32'h0);
        check_eq("rst_pc8_d", bus.pc8_d, 32'h8);
        check_eq("rst_valid_d", {31'b0, bus.valid_d}, 32'h0);
        check_eq("rst_fault", {31'b0, bus.fetch_fault}, 32'h0);
    endtask

    // Advance one clock edge with the currently driven inputs and verify.
    task automatic step_cycle();
        logic [31:0] n_pc_f;
        logic        fetch_ok;
        if (!bus.stall) begin
            if (bus.is_jr)
                n_pc_f = bus.jr_target;
            else if (bus.is_j)
                n_pc_f = ((m_pc_d + 32'd4) & 32'hF000_0000) | ({6'b0, bus.index26_d} * 32'd4);
            else if (bus.br)
                n_pc_f = m_pc_d + 32'd4 + 32'($signed(bus.imm16_d) * 4);
            else
                n_pc_f = m_pc_f + 32'd4;
            fetch_ok  = (m_pc_f % 32'd4 == 32'd0) && (m_pc_f >= RESET_PC)
                        && (m_pc_f < RESET_PC + IMEM_BYTES);
            m_instr_d = fetch_ok ? mem_word(m_pc_f) : 32'h0;
            m_valid_d = fetch_ok;
            m_pc_d    = m_pc_f;
            m_fault   = m_fault | !fetch_ok;
            m_pc_f    = n_pc_f;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_ctrl();
        bus.stall     = 1'b0;
        bus.br        = 1'b0;
        bus.is_j      = 1'b0;
        bus.is_jr     = 1'b0;
        bus.imm16_d   = 16'h0;
        bus.index26_d = 26'h0;
        bus.jr_target = 32'h0;
    endtask

    // Assert reset between edges, check outputs at once, release on a negedge.
    task automatic async_reset_pulse();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_values();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_until_pc_d(input logic [31:0] target);
        for (int i = 0; i < 64 && m_pc_d != target; i++) step_cycle();
        check_eq("reach_pc_d", bus.pc_d, target);
    endtask

    task automatic run_until_pc_f(input logic [31:0] target);
        for (int i = 0; i < 64 && m_pc_f != target; i++) step_cycle();
        check_eq("reach_pc_f", bus.imem_addr, target);
    endtask

    initial begin
        logic [31:0] snap_pc_f;
        logic [31:0] snap_instr;
        logic [31:0] snap_pc_d;
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        clear_ctrl();
        model_reset();
        #12;
        check_reset_values();
        reset_n = 1'b1;

        // Sequential fetch
        step_cycle();
        check_eq("seq_addr1", bus.imem_addr, 32'h3004);
        check_eq("seq_pc_d1", bus.pc_d, 32'h3000);
        check_eq("seq_valid1", {31'b0, bus.valid_d}, 32'h1);
        check_eq("seq_pc8_d1", bus.pc8_d, 32'h3008);
        step_cycle();
        check_eq("seq_addr2", bus.imem_addr, 32'h3008);
        check_eq("seq_pc_d2", bus.pc_d, 32'h3004);

        // Taken backward branch: delay slot enters IF/ID
        run_until_pc_d(32'h3010);
        bus.br      = 1'b1;
        bus.imm16_d = 16'hFFFC;
        step_cycle();
        check_eq("br_target", bus.imem_addr, 32'h3004);
        check_eq("br_slot_pc", bus.pc_d, 32'h3014);
        check_eq("br_slot_instr", bus.instr_d, mem_word(32'h3014));
        clear_ctrl();

        // Jump, then jr with br also asserted
        run_until_pc_d(32'h3020);
        bus.is_j      = 1'b1;
        bus.index26_d = 26'h0000C10;
        step_cycle();
        check_eq("j_target", bus.imem_addr, 32'h3040);
        clear_ctrl();
        bus.is_jr     = 1'b1;
        bus.jr_target = 32'h3100;
        bus.br        = 1'b1;
        bus.imm16_d   = 16'h0040;
        step_cycle();
        check_eq("jr_prio", bus.imem_addr, 32'h3100);
        clear_ctrl();
        step_cycle();

        // Stall with pending branch
        snap_pc_f   = bus.imem_addr;
        snap_instr  = bus.instr_d;
        snap_pc_d   = bus.pc_d;
        bus.stall   = 1'b1;
        bus.br      = 1'b1;
        bus.imm16_d = 16'h0004;
        for (int k = 0; k < 2; k++) begin
            step_cycle();
            check_eq("stall_pc_f", bus.imem_addr, snap_pc_f);
            check_eq("stall_instr", bus.instr_d, snap_instr);
            check_eq("stall_pc_d", bus.pc_d, snap_pc_d);
        end
        bus.stall = 1'b0;
        step_cycle();
        check_eq("stall_release_br", bus.imem_addr, snap_pc_d + 32'd20);
        clear_ctrl();

        // Out-of-range fetch and sticky fault
        bus.is_jr     = 1'b1;
        bus.jr_target = 32'h2FFC;
        step_cycle();
        clear_ctrl();
        step_cycle();
        check_eq("oor_instr", bus.instr_d, 32'h0);
        check_eq("oor_valid", {31'b0, bus.valid_d}, 32'h0);
        check_eq("oor_fault", {31'b0, bus.fetch_fault}, 32'h1);
        step_cycle();
        for (int k = 0; k < 3; k++) step_cycle();
        check_eq("fault_sticky", {31'b0, bus.fetch_fault}, 32'h1);
        check_eq("back_in_range", {31'b0, bus.valid_d}, 32'h1);

        // Mid-run asynchronous reset at pc_f = 0x3050
        async_reset_pulse();
        run_until_pc_f(32'h3050);
        async_reset_pulse();
        step_cycle();
        check_eq("post_rst_pc_d", bus.pc_d, RESET_PC);

        // Randomized control traffic
        for (int c = 0; c < 2000; c++) begin
            clear_ctrl();
            bus.stall     = ($urandom_range(99, 0) < 15);
            bus.br        = ($urandom_range(99, 0) < 12);
            bus.is_j      = ($urandom_range(99, 0) < 5);
            bus.is_jr     = ($urandom_range(99, 0) < 5);
            bus.imm16_d   = 16'($urandom_range(65535, 0));
            bus.index26_d = 26'((RESET_PC + 32'($urandom_range(4095, 0)) * 32'd4) >> 2);
            if ($urandom_range(9, 0) == 0)
                bus.jr_target = $urandom;
            else
                bus.jr_target = RESET_PC + 32'($urandom_range(4095, 0)) * 32'd4;
            if ($urandom_range(299, 0) == 0) begin
                async_reset_pulse();
            end else begin
                step_cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the program counter, computes the next PC from sequential, branch, jump and jump-register sources, and drives the instruction-memory address. It also owns the IF/ID pipeline register. It sits directly downstream of the ID-stage branch comparator and consumes its `Br` decision together with the ID-stage decode flags. Delayed-branch semantics apply: the delay slot is always executed, and there is no flush path.

## Interface
- `RESET_PC`, 32'h0000_3000: PC value after reset; also the base of instruction memory.
- `IMEM_WORDS`, 4096: instruction-memory depth in words; fetches outside it are faults.

- `clk` in 1: single clock, all state on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hazard-unit stall; freezes PC and IF/ID.
- `br` in 1: branch taken, from the branch comparator (already gated by IsBr).
- `is_j` in 1: ID instruction is j/jal.
- `is_jr` in 1: ID instruction is jr/jalr.
- `imm16_d` in 16: ID instruction immediate.
- `index26_d` in 26: ID instruction jump index.
- `jr_target` in 32: forwarded rs value for jr/jalr.
- `imem_addr` out 32: current fetch PC (`pc_f`).
- `imem_rdata` in 32: combinational instruction-memory read data for `imem_addr`.
- `instr_d` out 32: IF/ID instruction.
- `pc_d` out 32: IF/ID PC of `instr_d`.
- `pc8_d` out 32: `pc_d` + 8, the link value.
- `valid_d` out 1: IF/ID holds a real fetched instruction.
- `fetch_fault` out 1: sticky; set by the first out-of-range or misaligned fetch.

## Operation
- Next-PC sources, in priority order:
  - `is_jr`: `jr_target`.
  - `is_j`: {`pc_d`+4 [31:28], `index26_d`, 2'b00}.
  - `br`: `pc_d` + 4 + (sign-extended `imm16_d` << 2).
  - Otherwise: `pc_f` + 4.
- Decode guarantees the redirect sources are mutually exclusive. The priority order still applies if they are not.
- All arithmetic is modulo 2^32. Wrap-around at 32'hFFFF_FFFC goes to 0 and is not flagged; the range check catches it.
- Fetch is in range when `pc_f`[1:0] == 0 and (`pc_f` − `RESET_PC`) < 4·`IMEM_WORDS`, compared unsigned.
- Out-of-range fetch:
  - IF/ID loads `instr_d` = 32'h0 (nop) instead of `imem_rdata`, with `valid_d` = 0.
  - `fetch_fault` sets and holds until reset.
  - The PC keeps advancing normally.
- Stall:
  - `pc_f`, `instr_d`, `pc_d` and `valid_d` hold.
  - `br`, `is_j` and `is_jr` are ignored that cycle; the ID instruction re-evaluates them once the stall releases.
- `stall` together with a redirect: stall wins and there is no redirect.
- Delay slot: the word at `pc_d`+4 is already being fetched when the branch resolves in ID. It enters IF/ID normally on the same edge that loads the target into `pc_f`.

## Timing
- Reset values (asynchronous, immediate on `reset_n` low):
  - `pc_f` = `RESET_PC`.
  - `instr_d` = 0, `pc_d` = 0, `valid_d` = 0.
  - `pc8_d` = 8, since it is combinational from `pc_d`.
  - `fetch_fault` = 0.
- `reset_n` asserted mid-operation discards everything in flight. The first fetch after release is `RESET_PC`.
- Fetch latency is 1 cycle: `imem_addr` = P in cycle n gives `instr_d` = mem[P] and `pc_d` = P after edge n+1.
- Redirect latency: a branch in ID in cycle n puts the target on `imem_addr` in cycle n+1.
- There are no combinational paths from inputs to `instr_d`, `pc_d` or `valid_d`. `imem_addr` depends only on registered state.

## Structure
- Shared `define.v` holds `RESET_PC_DEFAULT`, `NOP_INSTR`, and the existing opcode/funct constants.
- One combinational sub-module, `npc`. It takes `pc_f`, `pc_d`, `imm16_d`, `index26_d`, `jr_target`, `br`, `is_j` and `is_jr`, and returns the next PC.
- `if_stage` wraps `npc` with the PC register, range check, IF/ID register and fault flag.

## Test plan
- **Reset and sequential fetch:** reset, release, 3 cycles, no stall → `imem_addr` = 0x3000, 0x3004, 0x3008; `pc_d` = 0x3000, 0x3004; `valid_d` = 1 from the first edge; `pc8_d` = 0x3008 with `pc_d` = 0x3000.
- **Taken branch with delay slot:** `pc_d` = 0x3010, `br` = 1, `imm16_d` = 16'hFFFC → next `imem_addr` = 0x3004; `instr_d` = word at 0x3014 (delay slot); `pc_d` = 0x3014.
- **Jump and jump-register:**
  - `is_j`, `pc_d` = 0x3020, `index26_d` = 0x0C10 → next PC 0x0000_3040.
  - `is_jr`, `jr_target` = 0x3100, with `br` also high → 0x3100 (jr priority).
- **Stall with redirect:** `stall` = 1 for 2 cycles with `br` = 1 → `pc_f`, `instr_d` and `pc_d` unchanged for both cycles. The stall drops with `br` still 1 → redirect taken on that edge.
- **Out-of-range fetch:** `jr_target` = 0x2FFC → next edge gives `instr_d` = 0, `valid_d` = 0, `fetch_fault` = 1. `fetch_fault` stays 1 after returning in range and clears only on `reset_n` low.
- **Asynchronous reset mid-run:** assert `reset_n` = 0 between clock edges at `pc_f` = 0x3050 → all outputs take reset values immediately, before the next edge.
